// File: rtl/uart_rx_cmd_ctrl_pkg.sv
// Command codes, FSM states and ALU operand addresses shared by the UART command controller.
// Pure definitions: no latency, no backpressure.
package uart_rx_cmd_ctrl_pkg;

    localparam logic [7:0] CMD_WR     = 8'hAA;
    localparam logic [7:0] CMD_RD     = 8'hBB;
    localparam logic [7:0] CMD_ALU_OP = 8'hCC;
    localparam logic [7:0] CMD_ALU    = 8'hDD;

    localparam int OP_A_ADDR = 0;
    localparam int OP_B_ADDR = 1;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WR_ADDR,
        ST_WR_DATA,
        ST_RD_ADDR,
        ST_RD_WAIT,
        ST_ALU_A,
        ST_ALU_B,
        ST_ALU_FUN,
        ST_ALU_WAIT,
        ST_TX_BYTE0,
        ST_TX_BYTE1
    } state_t;

    // States in which an incoming byte is consumed; others silently drop it.
    function automatic logic is_byte_accepting(input state_t s);
        return (s == ST_IDLE)   || (s == ST_WR_ADDR) || (s == ST_WR_DATA) ||
               (s == ST_RD_ADDR) || (s == ST_ALU_A)  || (s == ST_ALU_B)   ||
               (s == ST_ALU_FUN);
    endfunction

endpackage

// File: rtl/uart_rx_cmd_ctrl_if.sv
// Bundles UART receive, register-file, ALU and transmit handshakes of the command controller.
// master = controller side, slave = surrounding UART/register-file/ALU environment.
interface uart_rx_cmd_ctrl_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
);
    logic                      rx_valid;
    logic [DATA_WIDTH-1:0]     rx_data;
    logic                      rx_par_err;
    logic                      rx_stp_err;
    logic [ADDR_WIDTH-1:0]     rf_addr;
    logic                      rf_wr_en;
    logic                      rf_rd_en;
    logic [DATA_WIDTH-1:0]     rf_wr_data;
    logic [DATA_WIDTH-1:0]     rf_rd_data;
    logic                      rf_rd_valid;
    logic                      alu_en;
    logic [3:0]                alu_fun;
    logic [2*DATA_WIDTH-1:0]   alu_out;
    logic                      alu_out_valid;
    logic [DATA_WIDTH-1:0]     tx_data;
    logic                      tx_valid;
    logic                      tx_ready;
    logic                      frame_err;
    logic                      busy;

    modport master (
        input  rx_valid, rx_data, rx_par_err, rx_stp_err,
               rf_rd_data, rf_rd_valid, alu_out, alu_out_valid, tx_ready,
        output rf_addr, rf_wr_en, rf_rd_en, rf_wr_data, alu_en, alu_fun,
               tx_data, tx_valid, frame_err, busy
    );

    modport slave (
        output rx_valid, rx_data, rx_par_err, rx_stp_err,
               rf_rd_data, rf_rd_valid, alu_out, alu_out_valid, tx_ready,
        input  rf_addr, rf_wr_en, rf_rd_en, rf_wr_data, alu_en, alu_fun,
               tx_data, tx_valid, frame_err, busy
    );
endinterface

// File: rtl/uart_rx_cmd_ctrl.sv
// UART command decoder driving register-file writes/reads and ALU ops; UART_RX_CMD_ERR_DROP_EN drops errored bytes.
// Strobes one cycle after the triggering byte; tx_valid holds with stable data until tx_ready.
module uart_rx_cmd_ctrl
    import uart_rx_cmd_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic               CLK,
    input  logic               RST,
    uart_rx_cmd_ctrl_if.master bus
);

    state_t                  r_state;
    logic [ADDR_WIDTH-1:0]   r_rf_addr;
    logic                    r_rf_wr_en;
    logic                    r_rf_rd_en;
    logic [DATA_WIDTH-1:0]   r_rf_wr_data;
    logic                    r_alu_en;
    logic [3:0]              r_alu_fun;
    logic [DATA_WIDTH-1:0]   r_tx_data;
    logic                    r_tx_valid;
    logic [DATA_WIDTH-1:0]   r_tx_hi;
    logic                    r_two_byte;
    logic                    r_frame_err;
    logic                    w_rx_err;

`ifdef UART_RX_CMD_ERR_DROP_EN
    assign w_rx_err      = bus.rx_par_err | bus.rx_stp_err;
    assign bus.frame_err = r_frame_err;
`else
    logic w_unused_err;
    assign w_rx_err      = 1'b0;
    assign w_unused_err  = bus.rx_par_err | bus.rx_stp_err | r_frame_err;
    assign bus.frame_err = 1'b0;
`endif

    assign bus.rf_addr    = r_rf_addr;
    assign bus.rf_wr_en   = r_rf_wr_en;
    assign bus.rf_rd_en   = r_rf_rd_en;
    assign bus.rf_wr_data = r_rf_wr_data;
    assign bus.alu_en     = r_alu_en;
    assign bus.alu_fun    = r_alu_fun;
    assign bus.tx_data    = r_tx_data;
    assign bus.tx_valid   = r_tx_valid;
    assign bus.busy       = (r_state != ST_IDLE);

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state      <= ST_IDLE;
            r_rf_addr    <= '0;
            r_rf_wr_en   <= 1'b0;
            r_rf_rd_en   <= 1'b0;
            r_rf_wr_data <= '0;
            r_alu_en     <= 1'b0;
            r_alu_fun    <= '0;
            r_tx_data    <= '0;
            r_tx_valid   <= 1'b0;
            r_tx_hi      <= '0;
            r_two_byte   <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_rf_wr_en  <= 1'b0;
            r_rf_rd_en  <= 1'b0;
            r_alu_en    <= 1'b0;
            r_frame_err <= 1'b0;
            if (bus.rx_valid && w_rx_err && is_byte_accepting(r_state)) begin
                r_frame_err <= 1'b1;
                r_state     <= ST_IDLE;
            end else begin
                unique case (r_state)
                    ST_IDLE: if (bus.rx_valid) begin
                        if (bus.rx_data == DATA_WIDTH'(CMD_WR))          r_state <= ST_WR_ADDR;
                        else if (bus.rx_data == DATA_WIDTH'(CMD_RD))     r_state <= ST_RD_ADDR;
                        else if (bus.rx_data == DATA_WIDTH'(CMD_ALU_OP)) r_state <= ST_ALU_A;
                        else if (bus.rx_data == DATA_WIDTH'(CMD_ALU))    r_state <= ST_ALU_FUN;
                    end
                    ST_WR_ADDR: if (bus.rx_valid) begin
                        r_rf_addr <= bus.rx_data[ADDR_WIDTH-1:0];
                        r_state   <= ST_WR_DATA;
                    end
                    ST_WR_DATA: if (bus.rx_valid) begin
                        r_rf_wr_data <= bus.rx_data;
                        r_rf_wr_en   <= 1'b1;
                        r_state      <= ST_IDLE;
                    end
                    ST_RD_ADDR: if (bus.rx_valid) begin
                        r_rf_addr  <= bus.rx_data[ADDR_WIDTH-1:0];
                        r_rf_rd_en <= 1'b1;
                        r_state    <= ST_RD_WAIT;
                    end
                    ST_RD_WAIT: if (bus.rf_rd_valid) begin
                        r_tx_data  <= bus.rf_rd_data;
                        r_tx_valid <= 1'b1;
                        r_two_byte <= 1'b0;
                        r_state    <= ST_TX_BYTE0;
                    end
                    ST_ALU_A: if (bus.rx_valid) begin
                        r_rf_addr    <= ADDR_WIDTH'(OP_A_ADDR);
                        r_rf_wr_data <= bus.rx_data;
                        r_rf_wr_en   <= 1'b1;
                        r_state      <= ST_ALU_B;
                    end
                    ST_ALU_B: if (bus.rx_valid) begin
                        r_rf_addr    <= ADDR_WIDTH'(OP_B_ADDR);
                        r_rf_wr_data <= bus.rx_data;
                        r_rf_wr_en   <= 1'b1;
                        r_state      <= ST_ALU_FUN;
                    end
                    ST_ALU_FUN: if (bus.rx_valid) begin
                        r_alu_fun <= bus.rx_data[3:0];
                        r_alu_en  <= 1'b1;
                        r_state   <= ST_ALU_WAIT;
                    end
                    ST_ALU_WAIT: if (bus.alu_out_valid) begin
                        r_tx_data  <= bus.alu_out[DATA_WIDTH-1:0];
                        r_tx_hi    <= bus.alu_out[2*DATA_WIDTH-1:DATA_WIDTH];
                        r_tx_valid <= 1'b1;
                        r_two_byte <= 1'b1;
                        r_state    <= ST_TX_BYTE0;
                    end
                    ST_TX_BYTE0: if (bus.tx_ready) begin
                        r_tx_valid <= 1'b0;
                        r_state    <= r_two_byte ? ST_TX_BYTE1 : ST_IDLE;
                    end
                    // First cycle here has tx_valid low, giving the mandatory gap between bytes.
                    ST_TX_BYTE1: begin
                        if (!r_tx_valid) begin
                            r_tx_valid <= 1'b1;
                            r_tx_data  <= r_tx_hi;
                        end else if (bus.tx_ready) begin
                            r_tx_valid <= 1'b0;
                            r_state    <= ST_IDLE;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/uart_rx_cmd_ctrl.md
UART_RX_CMD_CTRL -- requirements
Module: uart_rx_cmd_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 8, byte width of received/transmitted data and register file data.
REQ-002 Parameter ADDR_WIDTH, default 4, register file address width.
REQ-003 CLK  input  1  single clock; all logic on rising edge.
REQ-004 RST  input  1  reset, synchronous, active-high.
REQ-005 rx_valid  input  1  one-cycle pulse per received byte (from UART receiver data_valid).
REQ-006 rx_data  input  DATA_WIDTH  received byte, valid when rx_valid=1.
REQ-007 rx_par_err, rx_stp_err  input  1 each  parity/stop error flags qualified by rx_valid.
REQ-008 rf_addr  output  ADDR_WIDTH  register file address.
REQ-009 rf_wr_en / rf_rd_en  output  1 each  one-cycle write/read strobes.
REQ-010 rf_wr_data  output  DATA_WIDTH  register file write data.
REQ-011 rf_rd_data  input  DATA_WIDTH; rf_rd_valid  input  1  read return.
REQ-012 alu_en  output  1  one-cycle ALU start; alu_fun  output  4  ALU function code.
REQ-013 alu_out  input  2*DATA_WIDTH; alu_out_valid  input  1  ALU result return.
REQ-014 tx_data  output  DATA_WIDTH; tx_valid  output  1; tx_ready  input  1  byte handoff to transmitter.
REQ-015 frame_err  output  1  one-cycle pulse on aborted frame; busy  output  1  high when FSM not IDLE.

Function
REQ-016 Command bytes decoded in IDLE: 0xAA write, 0xBB read, 0xCC ALU with operands, 0xDD ALU without operands; any other byte ignored, FSM stays IDLE.
REQ-017 States: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, ALU_A, ALU_B, ALU_FUN, ALU_WAIT, TX_BYTE0, TX_BYTE1.
REQ-018 Write: 0xAA -> WR_ADDR; next byte latched as address (low ADDR_WIDTH bits) -> WR_DATA; next byte drives rf_wr_data, rf_wr_en=1 for the cycle after that byte's rx_valid -> IDLE.
REQ-019 Read: 0xBB -> RD_ADDR; address byte -> rf_rd_en pulse next cycle -> RD_WAIT; rf_rd_valid captures rf_rd_data -> TX_BYTE0 (single byte) -> IDLE.
REQ-020 ALU with operands: 0xCC -> ALU_A; byte written to address 0 (rf_wr_en pulse) -> ALU_B; byte written to address 1 -> ALU_FUN; byte low 4 bits to alu_fun, alu_en pulse -> ALU_WAIT.
REQ-021 ALU without operands: 0xDD -> ALU_FUN directly.
REQ-022 ALU_WAIT: alu_out_valid captures alu_out -> TX_BYTE0 (low byte) -> TX_BYTE1 (high byte) -> IDLE.
REQ-023 TX handshake: tx_valid held high with stable tx_data until cycle where tx_ready=1; transfer occurs that cycle; tx_valid low at least one cycle between bytes.
REQ-024 rx_valid pulses in RD_WAIT, ALU_WAIT, TX_BYTE0, TX_BYTE1 are dropped without side effects.
REQ-025 rf_wr_en, rf_rd_en, alu_en never asserted together; each strobe exactly one cycle.
REQ-026 rf_addr, alu_fun, tx_data registered; hold last value when idle.

Reset
REQ-027 RST=1 at any clock edge forces IDLE and all outputs to 0, including mid-frame and mid-handshake; captured operands/results cleared.
REQ-028 RST has priority over rx_valid, rf_rd_valid and alu_out_valid in the same cycle.

Configuration
REQ-029 Macro UART_RX_CMD_ERR_DROP_EN: defined -> rx_valid with rx_par_err or rx_stp_err in any byte-accepting state discards the byte, pulses frame_err, returns to IDLE with no strobes; undefined -> error flags ignored, frame_err tied 0.

Structure
REQ-030 Shared package holds command-code constants (0xAA/0xBB/0xCC/0xDD), state enumeration, operand addresses 0 and 1.
REQ-031 Single module; no sub-module (TX sequencing is two FSM states, not a separate block).

Verification
REQ-032 Bytes 0xAA,0x05,0x3C -> one rf_wr_en pulse, rf_addr=5, rf_wr_data=0x3C, busy returns 0.
REQ-033 Bytes 0xBB,0x05; rf_rd_valid with 0x3C; tx_ready low 3 cycles then high -> tx_valid held 4 cycles, tx_data=0x3C, one transfer.
REQ-034 Bytes 0xCC,0x10,0x20,0x01; alu_out=0x1234 -> writes addr0=0x10, addr1=0x20, alu_fun=1, tx bytes 0x34 then 0x12.
REQ-035 Byte 0x55 in IDLE then 0xDD,0x02 -> 0x55 ignored, alu_en with alu_fun=2.
REQ-036 With UART_RX_CMD_ERR_DROP_EN: 0xAA,0x05 with rx_par_err=1 -> frame_err pulse, no rf_wr_en, IDLE.
REQ-037 RST asserted in ALU_WAIT -> next cycle IDLE, all outputs 0, later alu_out_valid ignored.
